// File: rtl/fp_addsub_dispatch_if.sv
// Request/response handshake bundle for fp_addsub_dispatch.
// The slave modport is the dispatcher's view; master is the producer/consumer side.
interface fp_addsub_dispatch_if #(
  parameter int TAG_W = 4
);
  logic             req_valid;
  logic             req_ready;
  logic             req_sub;
  logic [31:0]      req_a;
  logic [31:0]      req_b;
  logic [TAG_W-1:0] req_tag;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [31:0]      rsp_q;
  logic [TAG_W-1:0] rsp_tag;

  modport slave (
    input  req_valid, req_sub, req_a, req_b, req_tag, rsp_ready,
    output req_ready, rsp_valid, rsp_q, rsp_tag
  );

  modport master (
    output req_valid, req_sub, req_a, req_b, req_tag, rsp_ready,
    input  req_ready, rsp_valid, rsp_q, rsp_tag
  );
endinterface

// File: rtl/fp_addsub_dispatch.sv
// Issues tagged add/sub requests into a no-stall fp_addsub pipeline and re-pairs
// the in-order results with their tags in a credit-protected result FIFO.
module fp_addsub_dispatch #(
  parameter int TAG_W     = 4,
  parameter int OUT_DEPTH = 8,
  localparam int CW       = $clog2(OUT_DEPTH + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  fp_addsub_dispatch_if.slave  bus,
  output logic                 fp_do_fadd,
  output logic                 fp_do_fsub,
  output logic [31:0]          fp_a,
  output logic [31:0]          fp_b,
  input  logic [31:0]          fp_q,
  input  logic                 fp_valid,
  output logic [CW-1:0]        inflight,
  output logic                 err
);
  localparam int PW = $clog2(OUT_DEPTH);

  logic [31:0]      a_q, a_d, b_q, b_d;
  logic             fadd_q, fadd_d, fsub_q, fsub_d;
  logic [CW-1:0]    inflight_q, inflight_d, occ_q, occ_d;
  logic [PW-1:0]    tag_wr_q, tag_wr_d, tag_rd_q, tag_rd_d;
  logic [PW-1:0]    res_wr_q, res_wr_d, res_rd_q, res_rd_d;
  logic             err_q, err_d;

  logic [TAG_W-1:0] tag_mem     [OUT_DEPTH];
  logic [31:0]      res_q_mem   [OUT_DEPTH];
  logic [TAG_W-1:0] res_tag_mem [OUT_DEPTH];

  logic [CW:0]      used;
  logic             issue, ret_ok, pop, rsp_valid_w;

  // Every accepted op holds a result slot until it is popped, so the FIFO can never overflow.
  assign used          = {1'b0, inflight_q} + {1'b0, occ_q};
  assign bus.req_ready = rst && (used < (CW+1)'(OUT_DEPTH));

  assign issue       = bus.req_valid && bus.req_ready;
  assign ret_ok      = fp_valid && (inflight_q != '0);
  assign rsp_valid_w = (occ_q != '0);
  assign pop         = rsp_valid_w && bus.rsp_ready;

  assign bus.rsp_valid = rsp_valid_w;
  assign bus.rsp_q     = rsp_valid_w ? res_q_mem[res_rd_q]   : '0;
  assign bus.rsp_tag   = rsp_valid_w ? res_tag_mem[res_rd_q] : '0;

  assign fp_do_fadd = fadd_q;
  assign fp_do_fsub = fsub_q;
  assign fp_a       = a_q;
  assign fp_b       = b_q;
  assign inflight   = inflight_q;
  assign err        = err_q;

  always_comb begin
    a_d        = a_q;
    b_d        = b_q;
    fadd_d     = issue && !bus.req_sub;
    fsub_d     = issue && bus.req_sub;
    tag_wr_d   = tag_wr_q;
    tag_rd_d   = tag_rd_q;
    res_wr_d   = res_wr_q;
    res_rd_d   = res_rd_q;
    inflight_d = inflight_q + CW'(issue) - CW'(ret_ok);
    occ_d      = occ_q + CW'(ret_ok) - CW'(pop);
    err_d      = err_q || (fp_valid && (inflight_q == '0));
    if (issue) begin
      a_d      = bus.req_a;
      b_d      = bus.req_b;
      tag_wr_d = tag_wr_q + PW'(1);
    end
    if (ret_ok) begin
      tag_rd_d = tag_rd_q + PW'(1);
      res_wr_d = res_wr_q + PW'(1);
    end
    if (pop) begin
      res_rd_d = res_rd_q + PW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      a_q        <= '0;
      b_q        <= '0;
      fadd_q     <= 1'b0;
      fsub_q     <= 1'b0;
      tag_wr_q   <= '0;
      tag_rd_q   <= '0;
      res_wr_q   <= '0;
      res_rd_q   <= '0;
      inflight_q <= '0;
      occ_q      <= '0;
      err_q      <= 1'b0;
    end else begin
      a_q        <= a_d;
      b_q        <= b_d;
      fadd_q     <= fadd_d;
      fsub_q     <= fsub_d;
      tag_wr_q   <= tag_wr_d;
      tag_rd_q   <= tag_rd_d;
      res_wr_q   <= res_wr_d;
      res_rd_q   <= res_rd_d;
      inflight_q <= inflight_d;
      occ_q      <= occ_d;
      err_q      <= err_d;
    end
  end

  // Storage needs no reset: pointers and occupancy decide what is valid.
  always_ff @(posedge clk) begin
    if (issue) begin
      tag_mem[tag_wr_q] <= bus.req_tag;
    end
    if (ret_ok) begin
      res_q_mem[res_wr_q]   <= fp_q;
      res_tag_mem[res_wr_q] <= tag_mem[tag_rd_q];
    end
  end
endmodule

// File: tb/tb_fp_addsub_dispatch.sv
// Randomized self-checking bench for fp_addsub_dispatch with a fixed-latency
// behavioural fp_addsub pipeline and a credit/ordering reference model.
module tb_fp_addsub_dispatch;
  localparam int TAG_W = 4;
  localparam int DEPTH = 8;
  localparam int LAT   = 3;
  localparam int CW    = $clog2(DEPTH + 1);

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  fp_addsub_dispatch_if #(.TAG_W(TAG_W)) bus();

  logic             fp_do_fadd, fp_do_fsub;
  logic [31:0]      fp_a, fp_b, fp_q;
  logic             fp_valid;
  logic [CW-1:0]    inflight;
  logic             err;

  fp_addsub_dispatch #(.TAG_W(TAG_W), .OUT_DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .fp_do_fadd (fp_do_fadd),
    .fp_do_fsub (fp_do_fsub),
    .fp_a       (fp_a),
    .fp_b       (fp_b),
    .fp_q       (fp_q),
    .fp_valid   (fp_valid),
    .inflight   (inflight),
    .err        (err)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Single-precision <-> real helpers, exact for the normal/zero values used here.
  function automatic real s2r(input logic [31:0] s);
    logic [63:0] d;
    if (s[30:0] == 31'd0) d = {s[31], 63'd0};
    else d = {s[31], 11'(int'(s[30:23]) - 127 + 1023), s[22:0], 29'd0};
    return $bitstoreal(d);
  endfunction

  function automatic logic [31:0] r2s(input real r);
    logic [63:0] d;
    d = $realtobits(r);
    if (d[62:0] == 63'd0) return {d[63], 31'd0};
    return {d[63], 8'(int'(d[62:52]) - 1023 + 127), d[51:29]};
  endfunction

  function automatic logic [31:0] fp_arith(input logic [31:0] a, input logic [31:0] b, input bit sub);
    return sub ? r2s(s2r(a) - s2r(b)) : r2s(s2r(a) + s2r(b));
  endfunction

  function automatic logic [31:0] rand_fp();
    real r;
    r = real'($urandom_range(0, 4000));
    if ($urandom_range(0, 1) == 1) r = -r;
    return r2s(r);
  endfunction

  // Reference model state
  int               m_inflight = 0;
  int               m_buf = 0;
  bit               m_err = 1'b0;
  logic [35:0]      exp_q[$];
  bit               p_hs = 1'b0, p_sub = 1'b0;
  logic [31:0]      p_a = '0, p_b = '0;
  int               pipe_due[$];
  logic [31:0]      pipe_res[$];
  int               cyc = 0;

  // Values sampled at the most recent negedge
  bit               s_hs, s_pop, s_req_ready, s_rsp_valid, s_err;
  logic [31:0]      s_rsp_q;
  logic [TAG_W-1:0] s_rsp_tag;
  logic [CW-1:0]    s_inflight;

  task automatic clear_model();
    m_inflight = 0;
    m_buf      = 0;
    m_err      = 1'b0;
    p_hs       = 1'b0;
    exp_q.delete();
    pipe_due.delete();
    pipe_res.delete();
  endtask

  task automatic tick();
    bit ret_ok;
    logic [35:0] e;
    @(negedge clk);
    s_hs        = bus.req_valid && bus.req_ready;
    s_pop       = bus.rsp_valid && bus.rsp_ready;
    s_req_ready = bus.req_ready;
    s_rsp_valid = bus.rsp_valid;
    s_err       = err;
    s_rsp_q     = bus.rsp_q;
    s_rsp_tag   = bus.rsp_tag;
    s_inflight  = inflight;
    if (rst) begin
      check("inflight", 64'(inflight), 64'(m_inflight));
      check("rsp_valid", 64'(bus.rsp_valid), 64'(m_buf != 0));
      check("req_ready", 64'(bus.req_ready), 64'((m_inflight + m_buf) < DEPTH));
      check("err", 64'(err), 64'(m_err));
      check("fadd_pulse", 64'(fp_do_fadd), 64'(p_hs && !p_sub));
      check("fsub_pulse", 64'(fp_do_fsub), 64'(p_hs && p_sub));
      if (p_hs) begin
        check("fp_a", 64'(fp_a), 64'(p_a));
        check("fp_b", 64'(fp_b), 64'(p_b));
      end
      if (s_pop) begin
        if (exp_q.size() == 0) begin
          check("pop_unexpected", 64'(1), 64'(0));
        end else begin
          e = exp_q.pop_front();
          check("rsp_q", 64'(s_rsp_q), 64'(e[35:4]));
          check("rsp_tag", 64'(s_rsp_tag), 64'(e[3:0]));
        end
      end
      if (s_hs) exp_q.push_back({fp_arith(bus.req_a, bus.req_b, bus.req_sub), bus.req_tag});
      ret_ok = fp_valid && (m_inflight > 0);
      if (fp_valid && m_inflight == 0) m_err = 1'b1;
      m_inflight = m_inflight + int'(s_hs) - int'(ret_ok);
      m_buf      = m_buf + int'(ret_ok) - int'(s_pop);
      p_hs  = s_hs;
      p_sub = bus.req_sub;
      p_a   = bus.req_a;
      p_b   = bus.req_b;
    end
    @(posedge clk);
    #1;
    cyc++;
    fp_valid = 1'b0;
    if (!rst) begin
      pipe_due.delete();
      pipe_res.delete();
    end else begin
      if (fp_do_fadd || fp_do_fsub) begin
        pipe_due.push_back(cyc + LAT);
        pipe_res.push_back(fp_arith(fp_a, fp_b, fp_do_fsub));
      end
      if (pipe_due.size() > 0 && pipe_due[0] == cyc) begin
        fp_valid = 1'b1;
        fp_q     = pipe_res.pop_front();
        void'(pipe_due.pop_front());
      end
    end
  endtask

  task automatic drive(input bit v, input bit sub, input logic [31:0] a, input logic [31:0] b,
                       input logic [TAG_W-1:0] tag);
    bus.req_valid = v;
    bus.req_sub   = sub;
    bus.req_a     = a;
    bus.req_b     = b;
    bus.req_tag   = tag;
  endtask

  task automatic check_zero_outputs(input string pfx);
    check({pfx, "_req_ready"}, 64'(bus.req_ready), 64'(0));
    check({pfx, "_rsp_valid"}, 64'(bus.rsp_valid), 64'(0));
    check({pfx, "_rsp_q"},     64'(bus.rsp_q), 64'(0));
    check({pfx, "_rsp_tag"},   64'(bus.rsp_tag), 64'(0));
    check({pfx, "_inflight"},  64'(inflight), 64'(0));
    check({pfx, "_err"},       64'(err), 64'(0));
    check({pfx, "_pulses"},    64'({fp_do_fadd, fp_do_fsub}), 64'(0));
    check({pfx, "_fp_a"},      64'(fp_a), 64'(0));
    check({pfx, "_fp_b"},      64'(fp_b), 64'(0));
  endtask

  // One op with the consumer ready; waits (bounded) for accept and for the response.
  task automatic directed(input logic [31:0] a, input logic [31:0] b, input bit sub,
                          input logic [TAG_W-1:0] tag, input logic [31:0] expq, input string name);
    bit got;
    bus.rsp_ready = 1'b1;
    drive(1'b1, sub, a, b, tag);
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      tick();
      got = s_hs;
    end
    drive(1'b0, 1'b0, '0, '0, '0);
    if (!got) check({name, "_accept_timeout"}, 64'(0), 64'(1));
    got = 1'b0;
    for (int i = 0; i < 50 && !got; i++) begin
      tick();
      if (s_pop) begin
        got = 1'b1;
        check({name, "_q"}, 64'(s_rsp_q), 64'(expq));
        check({name, "_tag"}, 64'(s_rsp_tag), 64'(tag));
      end
    end
    if (!got) check({name, "_rsp_timeout"}, 64'(0), 64'(1));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int tag_i;
    bit got;
    fp_valid = 1'b0;
    fp_q     = '0;
    bus.rsp_ready = 1'b0;
    drive(1'b0, 1'b0, '0, '0, '0);
    #1;
    check_zero_outputs("reset");
    repeat (3) tick();
    rst = 1'b1;
    clear_model();

    directed(32'h3F800000, 32'h40000000, 1'b0, 4'd3, 32'h40400000, "add_1_2");
    directed(32'h40400000, 32'h3F800000, 1'b1, 4'd5, 32'h40000000, "sub_3_1");

    // Fill: consumer stalled, ten requests offered back-to-back
    bus.rsp_ready = 1'b0;
    tag_i = 0;
    for (int i = 0; i < 30; i++) begin
      drive(tag_i < 10, 1'(tag_i % 2), rand_fp(), rand_fp(), TAG_W'(tag_i));
      tick();
      if (s_hs) tag_i++;
    end
    check("fill_accepted", 64'(tag_i), 64'(8));
    check("fill_req_ready", 64'(s_req_ready), 64'(0));
    check("fill_inflight", 64'(s_inflight), 64'(0));

    // Pop while full: no accept in the pop cycle, accept on the next
    drive(1'b1, 1'b0, rand_fp(), rand_fp(), TAG_W'(8));
    bus.rsp_ready = 1'b1;
    tick();
    check("full_pop", 64'(s_pop), 64'(1));
    check("full_pop_no_accept", 64'(s_hs), 64'(0));
    bus.rsp_ready = 1'b0;
    tick();
    check("after_pop_accept", 64'(s_hs), 64'(1));
    drive(1'b1, 1'b1, rand_fp(), rand_fp(), TAG_W'(9));
    tick();
    check("occ8_req_ready", 64'(s_req_ready), 64'(0));
    bus.rsp_ready = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      tick();
      got = s_hs;
    end
    check("tag9_accepted", 64'(got), 64'(1));
    drive(1'b0, 1'b0, '0, '0, '0);
    repeat (40) tick();
    check("fill_drained", 64'(exp_q.size()), 64'(0));

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), rand_fp(), rand_fp(),
            TAG_W'($urandom()));
      bus.rsp_ready = ($urandom_range(0, 2) != 0);
      tick();
    end
    drive(1'b0, 1'b0, '0, '0, '0);
    bus.rsp_ready = 1'b1;
    repeat (40) tick();
    check("rand_drained", 64'(exp_q.size()), 64'(0));
    check("rand_inflight", 64'(s_inflight), 64'(0));

    // Stray result strobe with nothing in flight
    fp_valid = 1'b1;
    fp_q     = 32'hDEADBEEF;
    tick();
    repeat (3) tick();
    check("stray_err", 64'(s_err), 64'(1));
    check("stray_no_rsp", 64'(s_rsp_valid), 64'(0));

    // Reset with ops in flight and buffered
    bus.rsp_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 1'b0, rand_fp(), rand_fp(), TAG_W'(i));
      tick();
      check("pre_rst_accept", 64'(s_hs), 64'(1));
    end
    drive(1'b0, 1'b0, '0, '0, '0);
    tick();
    check("pre_rst_inflight", 64'(inflight), 64'(3));
    rst = 1'b0;
    fp_valid = 1'b0;
    #1;
    check_zero_outputs("midrst");
    clear_model();
    repeat (2) tick();
    rst = 1'b1;
    directed(32'h3F800000, 32'h3F800000, 1'b0, 4'd7, 32'h40000000, "post_rst_add");

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
